// File: rtl/scan_decoder_if.sv
// Bundle of control inputs and decoded outputs shared by scan_decoder and its driver.
// All outputs are registered inside the decoder; the master side owns the controls.
interface scan_decoder_if #(
  parameter int WIDTH       = 16,
  parameter int DWELL_WIDTH = 8
);
  localparam int IDX_W = $clog2(WIDTH);

  logic                   enable;
  logic [1:0]             mode;
  logic [IDX_W-1:0]       sel;
  logic                   load;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [WIDTH-1:0]       out;
  logic [IDX_W-1:0]       index;
  logic                   wrap;

  modport master (output enable, mode, sel, load, dwell, input out, index, wrap);
  modport slave  (input enable, mode, sel, load, dwell, output out, index, wrap);
endinterface

// File: rtl/scan_decoder.sv
// Registered WIDTH-line decoder: direct one-hot, thermometer fill, and up/down scanning
// with a programmable per-position dwell and a one-cycle wrap strobe.
module scan_decoder #(
  parameter int WIDTH       = 16,
  parameter int DWELL_WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,
  scan_decoder_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W:0]   WIDTH_L = (IDX_W + 1)'(WIDTH);
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(WIDTH - 1);
  localparam logic [1:0]       MODE_THERMO = 2'b01;

  logic [WIDTH-1:0]       out_q, out_d;
  logic [IDX_W-1:0]       index_q, index_d;
  logic                   wrap_q, wrap_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_WIDTH-1:0] dwell_reg_q, dwell_reg_d;
  logic [1:0]             mode_q, mode_d;
  logic                   mode_vld_q, mode_vld_d;
  logic                   sel_ok;
  logic                   mode_chg;
  logic                   blank;

  always_comb begin
    index_d     = index_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_reg_d = dwell_reg_q;
    mode_d      = mode_q;
    mode_vld_d  = mode_vld_q;
    wrap_d      = 1'b0;
    blank       = 1'b0;
    out_d       = '0;
    sel_ok      = ({1'b0, bus.sel} < WIDTH_L);
    // mode_vld_q keeps the first edge after reset from looking like a mode change
    mode_chg    = mode_vld_q && (bus.mode != mode_q);

    if (bus.enable) begin
      mode_d     = bus.mode;
      mode_vld_d = 1'b1;
      if (!bus.mode[1]) begin
        if (sel_ok) index_d = bus.sel;
        else        blank   = 1'b1;
        if (bus.load) begin
          dwell_reg_d = bus.dwell;
          dwell_cnt_d = bus.dwell;
        end else if (mode_chg) begin
          dwell_cnt_d = dwell_reg_q;
        end
      end else if (bus.load) begin
        index_d     = sel_ok ? bus.sel : MAX_IDX;
        dwell_reg_d = bus.dwell;
        dwell_cnt_d = bus.dwell;
      end else if (mode_chg) begin
        dwell_cnt_d = dwell_reg_q;
      end else if (dwell_cnt_q != '0) begin
        dwell_cnt_d = dwell_cnt_q - 1'b1;
      end else begin
        dwell_cnt_d = dwell_reg_q;
        if (!bus.mode[0]) begin
          if (index_q == MAX_IDX) begin
            index_d = '0;
            wrap_d  = 1'b1;
          end else begin
            index_d = index_q + 1'b1;
          end
        end else begin
          if (index_q == '0) begin
            index_d = MAX_IDX;
            wrap_d  = 1'b1;
          end else begin
            index_d = index_q - 1'b1;
          end
        end
      end

      // Decode the next index so out and index always agree in the same cycle
      if (!blank) begin
        for (int k = 0; k < WIDTH; k++) begin
          if (bus.mode == MODE_THERMO) out_d[k] = (IDX_W'(k) <= index_d);
          else                         out_d[k] = (IDX_W'(k) == index_d);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= '0;
      index_q     <= '0;
      wrap_q      <= 1'b0;
      dwell_cnt_q <= '0;
      dwell_reg_q <= '0;
      mode_q      <= '0;
      mode_vld_q  <= 1'b0;
    end else begin
      out_q       <= out_d;
      index_q     <= index_d;
      wrap_q      <= wrap_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_reg_q <= dwell_reg_d;
      mode_q      <= mode_d;
      mode_vld_q  <= mode_vld_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.index = index_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: a WIDTH=16 instance for the main modes and a
// WIDTH=12 instance for out-of-range sel handling.
module tb_scan_decoder;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  scan_decoder_if #(.WIDTH(16), .DWELL_WIDTH(8)) a_if ();
  scan_decoder_if #(.WIDTH(12), .DWELL_WIDTH(8)) b_if ();

  scan_decoder #(.WIDTH(16), .DWELL_WIDTH(8)) u_a (.clk(clk), .reset(reset), .bus(a_if));
  scan_decoder #(.WIDTH(12), .DWELL_WIDTH(8)) u_b (.clk(clk), .reset(reset), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic [15:0] e_out, input logic [3:0] e_idx,
                       input logic e_wrap);
    checks++;
    if (a_if.out !== e_out) begin
      failures++;
      $display("FAIL %s out: got %h expected %h", name, a_if.out, e_out);
    end
    checks++;
    if (a_if.index !== e_idx) begin
      failures++;
      $display("FAIL %s index: got %0d expected %0d", name, a_if.index, e_idx);
    end
    checks++;
    if (a_if.wrap !== e_wrap) begin
      failures++;
      $display("FAIL %s wrap: got %b expected %b", name, a_if.wrap, e_wrap);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (a_if.out !== 16'h0 || a_if.index !== 4'd0 || a_if.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_a: got out=%h idx=%0d wrap=%b expected 0/0/0", a_if.out, a_if.index, a_if.wrap);
    end
    checks++;
    if (b_if.out !== 12'h0 || b_if.index !== 4'd0 || b_if.wrap !== 1'b0) begin
      failures++;
      $display("FAIL reset_b: got out=%h idx=%0d wrap=%b expected 0/0/0", b_if.out, b_if.index, b_if.wrap);
    end
    reset = 1'b0;
  endtask

  task automatic test_direct();
    a_if.mode   = 2'b00;
    a_if.enable = 1'b1;
    for (int s = 0; s < 16; s++) begin
      a_if.sel = 4'(s);
      step();
      chk_a("direct", 16'h0001 << s, 4'(s), 1'b0);
      step();
      chk_a("direct_hold", 16'h0001 << s, 4'(s), 1'b0);
    end
  endtask

  task automatic test_thermo();
    a_if.mode = 2'b01;
    a_if.sel  = 4'd5;
    step();
    chk_a("thermo", 16'h003F, 4'd5, 1'b0);
    a_if.sel = 4'd15;
    step();
    chk_a("thermo_full", 16'hFFFF, 4'd15, 1'b0);
    a_if.sel = 4'd5;
    step();
    a_if.enable = 1'b0;
    a_if.sel    = 4'd9;
    step();
    chk_a("thermo_disabled", 16'h0000, 4'd5, 1'b0);
    step();
    chk_a("thermo_disabled2", 16'h0000, 4'd5, 1'b0);
    a_if.enable = 1'b1;
    a_if.sel    = 4'd5;
    step();
    chk_a("thermo_reenable", 16'h003F, 4'd5, 1'b0);
  endtask

  task automatic test_scan_up();
    int exp_i [10];
    exp_i = '{14, 14, 14, 15, 15, 15, 0, 0, 0, 1};
    a_if.mode  = 2'b10;
    a_if.sel   = 4'd14;
    a_if.dwell = 8'd2;
    a_if.load  = 1'b1;
    step();
    a_if.load = 1'b0;
    a_if.sel  = 4'd3;
    for (int i = 0; i < 10; i++) begin
      chk_a($sformatf("scan_up[%0d]", i), 16'h0001 << exp_i[i], 4'(exp_i[i]), (i == 6));
      if (i < 9) step();
    end
  endtask

  task automatic test_scan_down();
    int exp_i [4];
    exp_i = '{1, 0, 15, 14};
    a_if.mode  = 2'b11;
    a_if.sel   = 4'd1;
    a_if.dwell = 8'd0;
    a_if.load  = 1'b1;
    step();
    a_if.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_a($sformatf("scan_down[%0d]", i), 16'h0001 << exp_i[i], 4'(exp_i[i]), (i == 2));
      if (i < 3) step();
    end
    // Freeze mid-dwell: position 10 held 4 cycles total, 2 used before the freeze
    a_if.sel   = 4'd10;
    a_if.dwell = 8'd3;
    a_if.load  = 1'b1;
    step();
    a_if.load = 1'b0;
    chk_a("down_load10", 16'h0400, 4'd10, 1'b0);
    step();
    a_if.enable = 1'b0;
    a_if.load   = 1'b1;
    a_if.sel    = 4'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_a($sformatf("down_frozen[%0d]", i), 16'h0000, 4'd10, 1'b0);
    end
    a_if.load   = 1'b0;
    a_if.enable = 1'b1;
    step();
    chk_a("down_resume0", 16'h0400, 4'd10, 1'b0);
    step();
    chk_a("down_resume1", 16'h0400, 4'd10, 1'b0);
    step();
    chk_a("down_resume_step", 16'h0200, 4'd9, 1'b0);
  endtask

  task automatic test_mode_change();
    a_if.mode  = 2'b10;
    a_if.sel   = 4'd6;
    a_if.dwell = 8'd0;
    a_if.load  = 1'b1;
    step();
    a_if.load = 1'b0;
    chk_a("mc_load", 16'h0040, 4'd6, 1'b0);
    step();
    chk_a("mc_up", 16'h0080, 4'd7, 1'b0);
    a_if.mode = 2'b11;
    step();
    chk_a("mc_switch_hold", 16'h0080, 4'd7, 1'b0);
    step();
    chk_a("mc_down1", 16'h0040, 4'd6, 1'b0);
    step();
    chk_a("mc_down2", 16'h0020, 4'd5, 1'b0);
  endtask

  task automatic test_width12();
    b_if.mode   = 2'b00;
    b_if.enable = 1'b1;
    b_if.sel    = 4'd3;
    step();
    checks++;
    if (b_if.out !== 12'h008 || b_if.index !== 4'd3) begin
      failures++;
      $display("FAIL w12_direct: got out=%h idx=%0d expected 008/3", b_if.out, b_if.index);
    end
    b_if.sel = 4'd13;
    step();
    checks++;
    if (b_if.out !== 12'h000 || b_if.index !== 4'd3) begin
      failures++;
      $display("FAIL w12_out_of_range: got out=%h idx=%0d expected 000/3", b_if.out, b_if.index);
    end
    b_if.sel = 4'd11;
    step();
    checks++;
    if (b_if.out !== 12'h800 || b_if.index !== 4'd11) begin
      failures++;
      $display("FAIL w12_top: got out=%h idx=%0d expected 800/11", b_if.out, b_if.index);
    end
    b_if.sel   = 4'd2;
    step();
    b_if.mode  = 2'b10;
    b_if.sel   = 4'd13;
    b_if.dwell = 8'd0;
    b_if.load  = 1'b1;
    step();
    b_if.load = 1'b0;
    checks++;
    if (b_if.out !== 12'h800 || b_if.index !== 4'd11 || b_if.wrap !== 1'b0) begin
      failures++;
      $display("FAIL w12_clamp: got out=%h idx=%0d wrap=%b expected 800/11/0", b_if.out, b_if.index, b_if.wrap);
    end
    step();
    checks++;
    if (b_if.out !== 12'h001 || b_if.index !== 4'd0 || b_if.wrap !== 1'b1) begin
      failures++;
      $display("FAIL w12_wrap: got out=%h idx=%0d wrap=%b expected 001/0/1", b_if.out, b_if.index, b_if.wrap);
    end
    step();
    checks++;
    if (b_if.out !== 12'h002 || b_if.index !== 4'd1 || b_if.wrap !== 1'b0) begin
      failures++;
      $display("FAIL w12_after_wrap: got out=%h idx=%0d wrap=%b expected 002/1/0", b_if.out, b_if.index, b_if.wrap);
    end
  endtask

  task automatic test_reset_mid_scan();
    a_if.mode  = 2'b10;
    a_if.sel   = 4'd7;
    a_if.dwell = 8'd5;
    a_if.load  = 1'b1;
    step();
    a_if.load = 1'b0;
    step();
    chk_a("mid_before_reset", 16'h0080, 4'd7, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_a("mid_reset", 16'h0000, 4'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_a($sformatf("post_reset[%0d]", i), 16'h0001 << i, 4'(i), 1'b0);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    a_if.enable = 1'b0;
    a_if.mode   = 2'b00;
    a_if.sel    = '0;
    a_if.load   = 1'b0;
    a_if.dwell  = '0;
    b_if.enable = 1'b0;
    b_if.mode   = 2'b00;
    b_if.sel    = '0;
    b_if.load   = 1'b0;
    b_if.dwell  = '0;

    test_reset();
    test_direct();
    test_thermo();
    test_scan_up();
    test_scan_down();
    test_mode_change();
    test_width12();
    test_reset_mid_scan();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Registered, parametrised successor to the combinational one-hot decoder. It drives WIDTH select lines in several modes:
- direct one-hot from sel
- thermometer fill
- autonomous up/down scanning with a programmable dwell per position and a wrap strobe

It is used for row/column strobing and channel sequencing, where the one-hot output must be glitch-free and held for a programmable number of cycles.

Parameters:
WIDTH, 16, number of output lines; must be >= 2; need not be a power of two.
DWELL_WIDTH, 8, width of the dwell counter and of the dwell input.
IDX_W, $clog2(WIDTH), width of sel and index; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
enable  input  1  output enable and advance enable; low freezes state and blanks out
mode  input  2  00 DIRECT, 01 THERMO, 10 SCAN_UP, 11 SCAN_DOWN
sel  input  IDX_W  index source in DIRECT/THERMO; start index on load in SCAN modes
load  input  1  single-cycle strobe: capture dwell into dwell_reg; in SCAN modes also capture sel into index
dwell  input  DWELL_WIDTH  cycles-minus-one each scan position is held
out  output  WIDTH  registered decoded select lines
index  output  IDX_W  current registered index
wrap  output  1  one-cycle pulse when a scan wraps around

Behaviour:
- Reset (synchronous, highest priority over all inputs): out=0, index=0, wrap=0, dwell_cnt=0, dwell_reg=0.
- All outputs are registered. Latency from sel/enable/mode to out is 1 clock. out never decodes an index other than the one shown on index in the same cycle.
- Decode function:
  - DIRECT and SCAN modes: one-hot, out[index]=1.
  - THERMO: out[k]=1 for all k <= index.
  - enable low: out=0.
- DIRECT/THERMO, enable high:
  - If sel < WIDTH: index <= sel.
  - If sel >= WIDTH (possible when WIDTH is not a power of two): index holds its previous value and out <= 0 for that cycle.
  - load only updates dwell_reg; dwell_cnt <= dwell.
- SCAN_UP/SCAN_DOWN, enable high:
  - load (priority over advance): index <= sel, with an out-of-range sel clamped to WIDTH-1; dwell_reg <= dwell; dwell_cnt <= dwell; wrap=0.
  - Otherwise, if dwell_cnt != 0: dwell_cnt decrements and index holds.
  - Otherwise (dwell_cnt == 0): index steps (+1 up, -1 down) and dwell_cnt <= dwell_reg.
  - Each position is therefore held dwell_reg+1 cycles; dwell_reg=0 steps every cycle.
- Wrap:
  - UP: WIDTH-1 -> 0. DOWN: 0 -> WIDTH-1.
  - wrap=1 in the same cycle the wrapped index first appears; otherwise 0.
- enable low: index, dwell_cnt and dwell_reg are frozen, load is ignored, out=0, wrap=0. On re-enable, out shows the held index 1 cycle later and the scan resumes with the remaining dwell_cnt.
- Mode change:
  - index is kept; dwell_cnt <= dwell_reg on the cycle the new mode is first sampled, so no step occurs on that edge.
  - SCAN_UP <-> SCAN_DOWN reverses direction from the current index.
- Reset asserted mid-scan clears everything on that edge. The first step after reset release in a SCAN mode occurs after dwell_reg+1 cycles, i.e. 1 cycle since dwell_reg=0.
- No combinational path from any input to any output.

Test Plan:
1. Defaults, DIRECT, enable=1, sel sweeps 0..15, one per 2 cycles -> out=16'h0001<<sel one cycle after each change; index=sel; wrap stays 0.
2. THERMO, sel=5 -> out=16'h003F; enable=0 -> out=0 next cycle, index stays 5; enable=1 -> out=16'h003F again after 1 cycle.
3. SCAN_UP, load with sel=14, dwell=2 -> index 14 for 3 cycles, then 15 for 3 cycles, then 0 with wrap=1 for exactly that first cycle, then 1; out stays one-hot throughout.
4. SCAN_DOWN, load with sel=1, dwell=0 -> index 1, 0, 15 (wrap=1), 14 on consecutive cycles; enable dropped for 4 cycles mid-dwell -> index frozen and out=0; scan resumes on re-enable.
5. WIDTH=12, DIRECT, sel=13 -> out=0 and index holds its previous value; SCAN_UP, load with sel=13 -> index clamps to 11, next step -> 0 with wrap=1.
6. Reset pulsed for 1 cycle while SCAN_UP is at index=7 with dwell=5 -> next cycle out=0, index=0, wrap=0; with mode still SCAN_UP and enable=1, the index advances every cycle from 0.
